// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the 5-stage pipeline.
// Hazard controller state, control bundle and counter width.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        DWAIT,
        HALTED
    } hzd_state_t;

    localparam int HZD_CNT_W = 32;

    typedef struct packed {
        logic pc_wen;
        logic en_ifid;
        logic fl_ifid;
        logic en_idex;
        logic fl_idex;
        logic en_exmem;
        logic fl_exmem;
        logic en_memwb;
    } hzd_ctrl_t;

    localparam hzd_ctrl_t CTRL_RESET  = hzd_ctrl_t'(8'b0010_1010);
    localparam hzd_ctrl_t CTRL_FREEZE = hzd_ctrl_t'(8'b0000_0000);
    localparam hzd_ctrl_t CTRL_RUN    = hzd_ctrl_t'(8'b1101_0101);

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the EX load and the ID consumer.
// Register zero never carries a real dependency.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     mem2reg_ex,
    input  regbits_t Rt_ex,
    input  regbits_t Rs_id,
    input  regbits_t Rt_id,
    input  logic     uses_rt_id,
    output logic     hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (Rt_ex == Rs_id);
    assign rt_match = uses_rt_id && (Rt_ex == Rt_id);
    assign hazard   = mem2reg_ex && (Rt_ex != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline with sticky halt
// and a saturating stall-cycle counter.
module pipeline_hazard_controller
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = HZD_CNT_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_mem,
    input  logic             dWEN_mem,
    input  logic             halt_mem,
    input  logic             redirect_ex,
    input  logic             mem2reg_ex,
    input  regbits_t         Rt_ex,
    input  regbits_t         Rs_id,
    input  regbits_t         Rt_id,
    input  logic             uses_rt_id,
    output logic             pc_wen,
    output logic             enable_ifid,
    output logic             flush_ifid,
    output logic             enable_idex,
    output logic             flush_idex,
    output logic             enable_exmem,
    output logic             flush_exmem,
    output logic             enable_memwb,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    hzd_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    hzd_ctrl_t        ctrl;
    logic             lu_hazard;
    logic             dmem_req;
    logic             freeze;

    load_use_detect u_lud (
        .mem2reg_ex (mem2reg_ex),
        .Rt_ex      (Rt_ex),
        .Rs_id      (Rs_id),
        .Rt_id      (Rt_id),
        .uses_rt_id (uses_rt_id),
        .hazard     (lu_hazard)
    );

    assign dmem_req = dREN_mem | dWEN_mem;
    assign freeze   = ((state_q == RUN) && dmem_req && !dhit)
                   || ((state_q == DWAIT) && !dhit);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (halt_mem)
                    state_d = HALTED;
                else if (dmem_req && !dhit)
                    state_d = DWAIT;
            end
            DWAIT: begin
                if (dhit)
                    state_d = halt_mem ? HALTED : RUN;
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // Redirect outranks load-use: the dependent ID instruction is squashed anyway.
    always_comb begin
        ctrl = CTRL_RUN;
        if (!nRST) begin
            ctrl = CTRL_RESET;
        end else if (state_q == HALTED || freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (redirect_ex) begin
            ctrl.fl_ifid = 1'b1;
            ctrl.fl_idex = 1'b1;
        end else if (lu_hazard) begin
            ctrl.pc_wen  = 1'b0;
            ctrl.en_ifid = 1'b0;
            ctrl.fl_idex = 1'b1;
        end else if (!ihit) begin
            ctrl.pc_wen  = 1'b0;
            ctrl.fl_ifid = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != HALTED && !ctrl.pc_wen && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_wen       = ctrl.pc_wen;
    assign enable_ifid  = ctrl.en_ifid;
    assign flush_ifid   = ctrl.fl_ifid;
    assign enable_idex  = ctrl.en_idex;
    assign flush_idex   = ctrl.fl_idex;
    assign enable_exmem = ctrl.en_exmem;
    assign flush_exmem  = ctrl.fl_exmem;
    assign enable_memwb = ctrl.en_memwb;
    assign halt         = (state_q == HALTED);
    assign stall_cnt    = cnt_q;

endmodule
